// File: rtl/axis_bridge_pkg.sv
// Shared definitions for the AXIS packet bridge: default widths, reader FSM
// state encoding and the last-beat byte-enable mask helper.
package axis_bridge_pkg;

    localparam int unsigned DEF_WIDTH  = 256;
    localparam int unsigned DEF_LEN_W  = 14;
    // Widest keep vector the mask helper produces (data buses up to 1024 bits).
    localparam int unsigned MAX_KEEP_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CTRL   = 2'd1,
        ST_STREAM = 2'd2
    } rd_state_t;

    // Byte enables for a final beat holding 'rem' bytes; rem==0 means a full beat.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int unsigned rem);
        logic [MAX_KEEP_W-1:0] m;
        for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
            m[i] = (rem == 0) || (i < rem);
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry output buffer with valid/ready on both sides.
// Ports: clk, reset (sync, active-high); s_valid/s_ready/s_data write side;
// m_valid/m_ready/m_data read side; occupancy = entries currently held (0..2).
module axis_skid_buf2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign push      = s_valid && s_ready;
    assign pop       = m_valid && m_ready;
    assign s_ready   = (count != 2'd2);
    assign m_valid   = (count != 2'd0);
    assign occupancy = count;
    // Head entry is never overwritten while valid, so m_data is stable under backpressure.
    assign m_data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/rx_axis_pkt_reader.sv
// Reads packet lengths from a control FIFO and the matching data words from a
// data FIFO, emitting each packet as an AXI4-Stream burst with tkeep/tlast.
// Ports: clk, reset (sync, active-high); dfifo_* / cfifo_* FIFO read side
// (data valid one cycle after rden); m_axis_* stream master; pkt_cnt (packets
// completed, wraps), len_err_cnt (zero-length words dropped, saturates), busy.
module rx_axis_pkt_reader
    import axis_bridge_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               dfifo_rden,
    input  logic [WIDTH-1:0]   dfifo_dataout,
    input  logic               dfifo_rdempty,
    output logic               cfifo_rden,
    input  logic [LEN_W-1:0]   cfifo_dataout,
    input  logic               cfifo_rdempty,
    output logic [WIDTH-1:0]   m_axis_tdata,
    output logic [WIDTH/8-1:0] m_axis_tkeep,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    output logic [31:0]        pkt_cnt,
    output logic [15:0]        len_err_cnt,
    output logic               busy
);

    localparam int unsigned KEEP_W = WIDTH / 8;
    localparam int unsigned SUM_W  = LEN_W + 1;
    localparam int unsigned BUF_W  = WIDTH + KEEP_W + 1;

    rd_state_t         state, state_nxt;
    logic [LEN_W-1:0]  beats_left, beats_nxt;
    logic [KEEP_W-1:0] last_keep, last_keep_nxt;
    logic              inflight, infl_last;
    logic [KEEP_W-1:0] infl_keep;
    logic              rd_last;
    logic [KEEP_W-1:0] rd_keep;
    logic              len_err_inc;
    logic [SUM_W-1:0]  len_sum;
    logic [LEN_W-1:0]  len_beats, len_rem;
    logic [KEEP_W-1:0] len_keep;
    logic [1:0]        occupancy;
    logic [2:0]        fill;
    logic              buf_ready, pop, room, issue_ok;
    logic [BUF_W-1:0]  buf_in, buf_out;

    // Beat count and final-beat keep for the length word presented this cycle.
    always_comb begin
        len_sum   = {1'b0, cfifo_dataout} + SUM_W'(KEEP_W - 1);
        len_beats = LEN_W'(len_sum / SUM_W'(KEEP_W));
        len_rem   = LEN_W'(cfifo_dataout % LEN_W'(KEEP_W));
        len_keep  = KEEP_W'(keep_mask(32'(len_rem)));
    end

    // Buffer slots left after this cycle's pop; counting the pop sustains one beat per cycle.
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign fill     = 3'(occupancy) + 3'(inflight) - 3'(pop);
    assign room     = (fill < 3'd2);
    assign issue_ok = !reset && !dfifo_rdempty && room;

    // Next state and FIFO strobes; the first data read overlaps CTRL so the
    // first beat is valid three cycles after cfifo_rden.
    always_comb begin
        state_nxt     = state;
        beats_nxt     = beats_left;
        last_keep_nxt = last_keep;
        cfifo_rden    = 1'b0;
        dfifo_rden    = 1'b0;
        rd_last       = 1'b0;
        rd_keep       = '1;
        len_err_inc   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!cfifo_rdempty && !reset) begin
                    cfifo_rden = 1'b1;
                    state_nxt  = ST_CTRL;
                end
            end
            ST_CTRL: begin
                if (cfifo_dataout == '0) begin
                    len_err_inc = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    last_keep_nxt = len_keep;
                    beats_nxt     = len_beats;
                    state_nxt     = ST_STREAM;
                    if (issue_ok) begin
                        dfifo_rden = 1'b1;
                        beats_nxt  = len_beats - LEN_W'(1);
                        rd_last    = (len_beats == LEN_W'(1));
                        rd_keep    = rd_last ? len_keep : '1;
                    end
                end
            end
            ST_STREAM: begin
                if (beats_left != '0 && issue_ok) begin
                    dfifo_rden = 1'b1;
                    beats_nxt  = beats_left - LEN_W'(1);
                    rd_last    = (beats_left == LEN_W'(1));
                    rd_keep    = rd_last ? last_keep : '1;
                end
                if (beats_left == '0 && !inflight) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, read-tag pipeline and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            beats_left  <= '0;
            last_keep   <= '0;
            inflight    <= 1'b0;
            infl_last   <= 1'b0;
            infl_keep   <= '0;
            pkt_cnt     <= '0;
            len_err_cnt <= '0;
        end else begin
            state      <= state_nxt;
            beats_left <= beats_nxt;
            last_keep  <= last_keep_nxt;
            inflight   <= dfifo_rden;
            infl_last  <= rd_last;
            infl_keep  <= rd_keep;
            if (pop && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (len_err_inc && len_err_cnt != 16'hFFFF) begin
                len_err_cnt <= len_err_cnt + 16'd1;
            end
        end
    end

    assign busy   = (state != ST_IDLE) || (occupancy != 2'd0);
    assign buf_in = {infl_last, infl_keep, dfifo_dataout};

    axis_skid_buf2 #(
        .W (BUF_W)
    ) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (inflight),
        .s_ready   (buf_ready),
        .s_data    (buf_in),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready),
        .m_data    (buf_out),
        .occupancy (occupancy)
    );

    assign m_axis_tdata = buf_out[WIDTH-1:0];
    assign m_axis_tkeep = buf_out[WIDTH +: KEEP_W];
    assign m_axis_tlast = buf_out[WIDTH + KEEP_W];

    // Reads are only issued with a free slot reserved, so returning data always fits.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) inflight |-> buf_ready);

endmodule

// File: tb/tb_rx_axis_pkt_reader.sv
// Self-checking bench for rx_axis_pkt_reader: behavioural FIFO models feed
// random packets, expected beats come from the byte-length rule.
module tb_rx_axis_pkt_reader;

    localparam int unsigned WIDTH  = 256;
    localparam int unsigned LEN_W  = 14;
    localparam int unsigned KEEP_W = WIDTH / 8;

    logic              clk;
    logic              reset;
    logic              dfifo_rden;
    logic [WIDTH-1:0]  dfifo_dataout;
    logic              dfifo_rdempty;
    logic              cfifo_rden;
    logic [LEN_W-1:0]  cfifo_dataout;
    logic              cfifo_rdempty;
    logic [WIDTH-1:0]  m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [31:0]       pkt_cnt;
    logic [15:0]       len_err_cnt;
    logic              busy;

    rx_axis_pkt_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .dfifo_rden    (dfifo_rden),
        .dfifo_dataout (dfifo_dataout),
        .dfifo_rdempty (dfifo_rdempty),
        .cfifo_rden    (cfifo_rden),
        .cfifo_dataout (cfifo_dataout),
        .cfifo_rdempty (cfifo_rdempty),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .pkt_cnt       (pkt_cnt),
        .len_err_cnt   (len_err_cnt),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]  data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    int               cq[$];
    logic [WIDTH-1:0] dq[$];
    beat_t            exp_q[$];

    int n_tests, n_fail;
    int exp_pkts, exp_err;
    int n_dreads, n_beats, cyc;
    int first_valid_cyc, crden_cyc;
    int tready_pct;
    bit stall_en, chk_bubble, in_pkt, hold_prev;
    bit c_pend, d_pend;
    logic [LEN_W-1:0]  c_word;
    logic [WIDTH-1:0]  d_word;
    logic [WIDTH-1:0]  prev_data;
    logic [KEEP_W-1:0] prev_keep;
    logic              prev_last;

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < int'(WIDTH / 32); i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Queue one packet: its length word, its data words and the beats it must produce.
    task automatic add_pkt(input int len);
        int    beats;
        beat_t b;
        cq.push_back(len);
        if (len == 0) begin
            exp_err++;
        end else begin
            beats = (len + int'(KEEP_W) - 1) / int'(KEEP_W);
            for (int i = 0; i < beats; i++) begin
                b.data = rand_word();
                dq.push_back(b.data);
                for (int k = 0; k < int'(KEEP_W); k++) b.keep[k] = ((i * int'(KEEP_W) + k) < len);
                b.last = (i == beats - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // One clock: drive FIFO outputs after the edge, then observe and check at the falling edge.
    task automatic step();
        beat_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (c_pend) cfifo_dataout = c_word;
        if (d_pend) dfifo_dataout = d_word;
        c_pend        = 1'b0;
        d_pend        = 1'b0;
        cfifo_rdempty = (cq.size() == 0);
        dfifo_rdempty = (dq.size() == 0) || (stall_en && ($urandom_range(0, 1) == 1));
        m_axis_tready = ($urandom_range(0, 99) < tready_pct);
        @(negedge clk);
        if (cfifo_rden) begin
            n_tests++;
            if (cfifo_rdempty) begin
                n_fail++;
                $display("FAIL cfifo_rden_while_empty: rden=1 rdempty=%b required no read", cfifo_rdempty);
            end else begin
                c_word = LEN_W'(cq.pop_front());
                c_pend = 1'b1;
                if (crden_cyc < 0) crden_cyc = cyc;
            end
        end
        if (dfifo_rden) begin
            n_tests++;
            n_dreads++;
            if (dfifo_rdempty) begin
                n_fail++;
                $display("FAIL dfifo_rden_while_empty: rden=1 rdempty=%b required no read", dfifo_rdempty);
            end else begin
                d_word = dq.pop_front();
                d_pend = 1'b1;
            end
        end
        if (hold_prev) begin
            n_tests++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                m_axis_tkeep !== prev_keep || m_axis_tlast !== prev_last) begin
                n_fail++;
                $display("FAIL hold_stable: tvalid=%b keep=%h last=%b required tvalid=1 keep=%h last=%b data unchanged",
                         m_axis_tvalid, m_axis_tkeep, m_axis_tlast, prev_keep, prev_last);
            end
        end
        if (m_axis_tvalid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (chk_bubble && in_pkt && m_axis_tready) begin
            n_tests++;
            if (m_axis_tvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL no_bubble: tvalid=%b inside packet required 1", m_axis_tvalid);
            end
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
            n_tests++;
            n_beats++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got keep=%h last=%b required no beat", m_axis_tkeep, m_axis_tlast);
            end else begin
                e = exp_q.pop_front();
                if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep || m_axis_tlast !== e.last) begin
                    n_fail++;
                    $display("FAIL beat: got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast, e.data, e.keep, e.last);
                end
                if (e.last) exp_pkts++;
                in_pkt = !e.last;
            end
        end
        hold_prev = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
        prev_keep = m_axis_tkeep;
        prev_last = m_axis_tlast;
    endtask

    task automatic run_idle(input int max_cycles);
        int n;
        n = 0;
        while (n < max_cycles && (exp_q.size() != 0 || cq.size() != 0 || c_pend || busy)) begin
            step();
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0 || cq.size() != 0 || c_pend || busy) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d beats and %0d ctrl words pending after %0d cycles, required 0",
                     exp_q.size(), cq.size(), max_cycles);
        end
    endtask

    task automatic check_counts(input string name);
        n_tests++;
        if (pkt_cnt !== 32'(exp_pkts) || len_err_cnt !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL %s_counters: pkt_cnt=%0d len_err_cnt=%0d required %0d %0d",
                     name, pkt_cnt, len_err_cnt, exp_pkts, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests += 9;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0)  begin n_fail++; $display("FAIL rst_tlast: got %b required 0", m_axis_tlast); end
        if (m_axis_tkeep !== '0)    begin n_fail++; $display("FAIL rst_tkeep: got %h required 0", m_axis_tkeep); end
        if (m_axis_tdata !== '0)    begin n_fail++; $display("FAIL rst_tdata: got %h required 0", m_axis_tdata); end
        if (cfifo_rden !== 1'b0)    begin n_fail++; $display("FAIL rst_cfifo_rden: got %b required 0", cfifo_rden); end
        if (dfifo_rden !== 1'b0)    begin n_fail++; $display("FAIL rst_dfifo_rden: got %b required 0", dfifo_rden); end
        if (pkt_cnt !== 32'd0)      begin n_fail++; $display("FAIL rst_pkt_cnt: got %0d required 0", pkt_cnt); end
        if (len_err_cnt !== 16'd0)  begin n_fail++; $display("FAIL rst_len_err_cnt: got %0d required 0", len_err_cnt); end
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_len64();
        int b0;
        b0 = n_beats;
        first_valid_cyc = -1;
        crden_cyc       = -1;
        add_pkt(64);
        run_idle(100);
        n_tests++;
        if (first_valid_cyc - crden_cyc != 3) begin
            n_fail++;
            $display("FAIL latency: first tvalid %0d cycles after cfifo_rden, required 3", first_valid_cyc - crden_cyc);
        end
        n_tests++;
        if (n_beats - b0 != 2) begin n_fail++; $display("FAIL len64_beats: got %0d required 2", n_beats - b0); end
        check_counts("len64");
    endtask

    task automatic test_len33_len1();
        int b0;
        b0 = n_beats;
        add_pkt(33);
        add_pkt(1);
        run_idle(100);
        n_tests++;
        if (n_beats - b0 != 3) begin n_fail++; $display("FAIL len33_1_beats: got %0d required 3", n_beats - b0); end
        check_counts("len33_1");
    endtask

    task automatic test_len_zero();
        int r0;
        r0 = n_dreads;
        add_pkt(0);
        add_pkt(32);
        run_idle(100);
        n_tests++;
        if (n_dreads - r0 != 1) begin n_fail++; $display("FAIL len0_reads: got %0d dfifo reads required 1", n_dreads - r0); end
        check_counts("len0");
    endtask

    task automatic test_back_to_back();
        int b0;
        b0         = n_beats;
        chk_bubble = 1'b1;
        repeat (3) add_pkt(96);
        run_idle(200);
        chk_bubble = 1'b0;
        n_tests++;
        if (n_beats - b0 != 9) begin n_fail++; $display("FAIL b2b_beats: got %0d required 9", n_beats - b0); end
        check_counts("b2b");
    endtask

    task automatic test_random_bp();
        int b0;
        b0         = n_beats;
        tready_pct = 50;
        stall_en   = 1'b1;
        add_pkt(320);
        run_idle(600);
        n_tests++;
        if (n_beats - b0 != 10) begin n_fail++; $display("FAIL bp_beats: got %0d required 10", n_beats - b0); end
        check_counts("bp");
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 8; i++) add_pkt(int'($urandom_range(0, 200)));
        run_idle(2000);
        check_counts("mix");
        tready_pct = 100;
        stall_en   = 1'b0;
    endtask

    task automatic test_reset_mid();
        int b0, n;
        add_pkt(256);
        b0 = n_beats;
        n  = 0;
        while (n_beats - b0 < 2 && n < 100) begin
            step();
            n++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        cq.delete();
        dq.delete();
        exp_q.delete();
        c_pend = 1'b0; d_pend = 1'b0; hold_prev = 1'b0; in_pkt = 1'b0;
        exp_pkts = 0; exp_err = 0;
        cfifo_rdempty = 1'b1;
        dfifo_rdempty = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 32'd0 || len_err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset: tvalid=%b busy=%b pkt_cnt=%0d len_err_cnt=%0d required all 0",
                     m_axis_tvalid, busy, pkt_cnt, len_err_cnt);
        end
        b0 = n_beats;
        add_pkt(32);
        run_idle(100);
        n_tests++;
        if (n_beats - b0 != 1) begin n_fail++; $display("FAIL post_reset_beats: got %0d required 1", n_beats - b0); end
        check_counts("post_reset");
    endtask

    initial begin
        n_tests = 0; n_fail = 0; exp_pkts = 0; exp_err = 0;
        n_dreads = 0; n_beats = 0; cyc = 0;
        first_valid_cyc = -1; crden_cyc = -1;
        tready_pct = 100; stall_en = 1'b0; chk_bubble = 1'b0;
        in_pkt = 1'b0; hold_prev = 1'b0; c_pend = 1'b0; d_pend = 1'b0;
        c_word = '0; d_word = '0; prev_data = '0; prev_keep = '0; prev_last = 1'b0;
        reset = 1'b1;
        cfifo_rdempty = 1'b1;
        dfifo_rdempty = 1'b1;
        cfifo_dataout = '0;
        dfifo_dataout = '0;
        m_axis_tready = 1'b0;
        test_reset();
        test_len64();
        test_len33_len1();
        test_len_zero();
        test_back_to_back();
        test_random_bp();
        test_random_mix();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
